// File: rtl/pll_lock_ctrl.sv
// Reset/lock sequencer for the CPU clock PLL: pulses the PLL reset, waits for a
// stable synchronized lock, releases the system reset, retries and latches a fault.
//
//   state       | meaning
//   ------------+--------------------------------------------------------------
//   S_RESET_PLL | pll_rst held high for RST_PULSE_CYCLES
//   S_WAIT_LOCK | waiting up to LOCK_TIMEOUT_CYCLES for lock_s
//   S_STABLE    | lock_s must stay high LOCK_STABLE_CYCLES in a row
//   S_RUN       | system released; any lock drop restarts the PLL
//   S_FAULT     | too many timeouts; held until rst
module pll_lock_ctrl #(
    parameter int unsigned RST_PULSE_CYCLES    = 100,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int unsigned CNT_MAX_A =
        (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX =
        (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync1_q, lock_s_q;
    logic             pll_rst_q, sys_rst_q, ready_q, fault_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                // Lock seen on the timeout cycle still counts as a lock.
                if (lock_s_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + 4'd1;
                    cnt_d   = '0;
                    state_d = (retry_d == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
                end
            end
            S_STABLE: begin
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d = S_RESET_PLL;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            S_FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            sync1_q   <= pll_locked;
            lock_s_q  <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
            sys_rst_q <= (state_d != S_RUN);
            ready_q   <= (state_d == S_RUN);
            fault_q   <= (state_d == S_FAULT);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Reset/lock sequencer for the CPU clock PLL. Runs on the 50 MHz PLL reference clock and drives the PLL reset. It waits for a stable lock, then releases the downstream system reset. It restarts the PLL on lock timeout or loss of lock, and latches a fault after repeated failed attempts.

## Interface
Parameters:
- RST_PULSE_CYCLES, 100 — cycles pll_rst is held high per attempt (2 µs at 50 MHz); ≥1
- LOCK_TIMEOUT_CYCLES, 50000 — cycles to wait for lock before retrying (1 ms); ≥1
- LOCK_STABLE_CYCLES, 1024 — consecutive synchronized-lock-high cycles required before release; ≥1
- MAX_RETRIES, 3 — lock timeouts tolerated before FAULT; 1..15

Ports:
- refclk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- pll_locked  in  1  PLL locked output; asynchronous to refclk
- pll_rst  out  1  PLL reset request, active-high
- sys_rst  out  1  downstream system reset, active-high
- ready  out  1  high only while in RUN
- fault  out  1  high only while in FAULT
- retry_cnt  out  4  timeouts since last entry to RUN
- loss_cnt  out  8  lock losses seen in RUN; saturates at 255

## Operation
- pll_locked passes through a 2-flop synchronizer. Its output is lock_s. Both flops reset to 0.
- A single counter cnt is shared by all states. It clears on every state transition. Its width is sized for the largest count parameter.
- States and transitions:
  - RESET_PLL: cnt increments. Leave when cnt == RST_PULSE_CYCLES-1, going to WAIT_LOCK.
  - WAIT_LOCK:
    - If lock_s=1, go to STABLE.
    - Else, when cnt == LOCK_TIMEOUT_CYCLES-1, retry_cnt increments. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
    - Lock wins when lock_s=1 on the timeout cycle.
  - STABLE:
    - If lock_s=0, go to WAIT_LOCK. cnt clears and the timeout restarts; retry_cnt is unchanged.
    - Else, when cnt == LOCK_STABLE_CYCLES-1, go to RUN and clear retry_cnt.
    - Lock drop wins on the final cycle.
  - RUN: if lock_s=0, increment loss_cnt (saturating) and go to RESET_PLL.
  - FAULT: terminal; only rst exits.
- Outputs are Moore outputs, valid in exactly the cycles the state register holds the state:
  - pll_rst = 1 in RESET_PLL and FAULT.
  - sys_rst = 1 in every state except RUN.
  - ready = 1 in RUN only.
  - fault = 1 in FAULT only.
- rst=1 at any time, including mid-operation, on the next edge:
  - state → RESET_PLL, cnt=0, retry_cnt=0, loss_cnt=0, synchronizer cleared.
- Output values while rst is held: pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, loss_cnt=0.

## Timing
- After rst deasserts, pll_rst stays high exactly RST_PULSE_CYCLES cycles per attempt.
- Lock path: pll_locked rises before edge k. Then:
  - lock_s is high after edge k+1.
  - STABLE begins after edge k+2.
  - RUN begins after edge k+2+LOCK_STABLE_CYCLES.
  - sys_rst falls and ready rises in the same cycle.
- Lock-loss path: pll_locked falls before edge k (in RUN). Then:
  - RESET_PLL begins after edge k+2.
  - sys_rst=1, ready=0, and loss_cnt increments, all in that same cycle.
- Timeout: WAIT_LOCK lasts LOCK_TIMEOUT_CYCLES cycles when lock_s stays 0.
- Never locking: FAULT is reached MAX_RETRIES·(RST_PULSE_CYCLES+LOCK_TIMEOUT_CYCLES) cycles after rst release.
- A lock pulse shorter than 2 cycles may be missed by the synchronizer. The bench must not require its detection.

## Test plan
Use parameters RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean lock:
  - Stimulus: release rst; raise pll_locked 3 cycles after pll_rst falls and hold it.
  - Required: pll_rst high exactly 4 cycles. ready rises and sys_rst falls 10 cycles after the pll_locked edge. retry_cnt=0.
- Unstable lock:
  - Stimulus: pll_locked high 5 cycles during STABLE, then low.
  - Required: return to WAIT_LOCK; ready never asserts; a full 32-cycle timeout follows; retry_cnt becomes 1 and pll_rst pulses 4 cycles.
- No lock:
  - Stimulus: hold pll_locked=0 from rst release.
  - Required: fault=1 and pll_rst=1 at cycle 72; retry_cnt=2. The block stays in FAULT with pll_locked later high, until a 1-cycle rst pulse; after it, fault=0 and a new attempt starts.
- Loss in RUN:
  - Stimulus: in RUN, drop pll_locked for 20 cycles, then restore it.
  - Required: 3 cycles after the drop, sys_rst=1, ready=0, loss_cnt=1. pll_rst pulses 4 cycles, then RUN is re-entered and retry_cnt=0.
- Timeout-edge tie:
  - Stimulus: lock_s first high on WAIT_LOCK cycle 31.
  - Required: STABLE entered; retry_cnt unchanged.
- Saturation and reset mid-run:
  - Stimulus: 260 lock-loss/relock cycles, then rst asserted during RUN.
  - Required: loss_cnt holds at 255. One cycle after rst, pll_rst=1, sys_rst=1, ready=0, loss_cnt=0.
